lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares the single 128x16 LC-3 memory between two requesters: the UART debug command path (host: r/w commands) and the CPU core (cpu: fetch, LD/LDR, ST/STR).
- Sits between both requesters and the external synchronous-read memory array.
- Sequences each access through a fixed issue/response pipeline.
- Arbitrates with round-robin or fixed host priority, and counts contention events.

Parameters:
- AW, 8, address width presented by requesters.
- DW, 16, data word width.
- DEPTH, 128, implemented words; addresses >= DEPTH are out of range.
- FIXED_PRIO, 0, 0 = round-robin; 1 = host always wins on conflict.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- host_req  in  1  host access request; held with fields stable until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  word address.
- host_wdata  in  DW  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  read data; valid with host_ack, held afterwards.
- host_err  out  1  pulses with host_ack when the address was out of range.
- cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack, cpu_rdata, cpu_err: same as the host_* ports, for the CPU.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  7  memory word address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en.
- conflict_cnt  out  8  count of cycles in IDLE with both requests eligible; wraps 255->0.

Behaviour:
- States: IDLE, ISSUE, RESP.
- IDLE -> ISSUE when at least one eligible request is present.
  - Winner, we, addr and wdata are latched on that edge.
  - last_grant is updated to the winner.
- ISSUE -> RESP unconditionally.
  - mem_en=1 only if the latched addr < DEPTH; mem_we = latched we.
  - mem_addr = addr[6:0]; mem_wdata = latched wdata.
  - mem_en, mem_we, mem_addr and mem_wdata are decoded from state and latches only, never from live request inputs.
- RESP -> IDLE unconditionally. On that edge, for the winner:
  - ack<=1 for exactly one cycle.
  - If read and in range: rdata<=mem_rdata.
  - If read and out of range: rdata<=0.
  - On write: rdata is unchanged.
  - err<=(addr >= DEPTH).
- Out-of-range write: no memory strobe; the access is still acked.
- Latency: request sampled at edge E0 -> memory strobe during cycle E0..E1 -> ack visible after E2. One access every 3 cycles maximum.
- Eligibility: a port whose ack is high in the current cycle is not eligible. This prevents double-servicing a request still high during its ack cycle. The other port may be granted in that same cycle.
- Arbitration, FIXED_PRIO=0:
  - Single eligible request wins.
  - Both eligible: the port not equal to last_grant wins.
  - last_grant resets to cpu, so the first conflict goes to host.
- Arbitration, FIXED_PRIO=1: host wins every conflict.
- Requests are not preempted. A request arriving in ISSUE/RESP waits; it is never lost while req stays high.
- conflict_cnt increments on each IDLE cycle where both ports are eligible.
- Reset (rst low, asynchronous):
  - state=IDLE, last_grant=cpu.
  - host_ack=cpu_ack=0, host_err=cpu_err=0.
  - host_rdata=cpu_rdata=0, conflict_cnt=0.
  - mem_en=mem_we=0 immediately.
  - A write latched in ISSUE when rst falls before the edge must not reach memory.
  - After release, both ports start fresh; a held req is re-arbitrated from IDLE.
- Address MSBs: only addr[6:0] drives memory. Bit 7 (and above) determines out-of-range status only.

Decomposition:
- Shared package lc3_mem_pkg:
  - AW, DW, DEPTH constants.
  - State encoding enum (IDLE/ISSUE/RESP).
  - Port-select encoding (PORT_HOST, PORT_CPU).
- One sub-module: rr_arb2, the combinational 2-way round-robin/fixed-priority grant logic.
  - Inputs: eligible vector, last_grant, FIXED_PRIO.
  - Output: one-hot grant.
- The state machine, latches, response registers and counter stay in lc3_mem_arbiter.

Test Plan:
- Host write then read: host writes 0x30<=0xBEEF, then reads 0x30. Expect host_ack exactly 3 cycles after each req, host_rdata=0xBEEF, and exactly one mem_we pulse at mem_addr=0x30.
- Simultaneous requests, FIXED_PRIO=0: host reads 0x10 and cpu reads 0x11 in the same cycle, 5 back-to-back rounds. Expect grants host, cpu, host, cpu, ..., each cpu access no more than 3 cycles after the preceding host ack, and conflict_cnt incremented per IDLE conflict cycle.
- Same stimulus, FIXED_PRIO=1: host holds req continuously. Expect cpu never granted while host is eligible. When host drops req, cpu is acked within 3 cycles.
- Out of range: cpu writes 0x80<=0x1234, then host reads 0x80. Expect no mem_en on the write, cpu_err pulse with cpu_ack, host_rdata=0x0000, host_err=1.
- Ack masking: host holds req one extra cycle after host_ack. Expect no second access and no second host_ack.
- Reset mid-write: assert rst low during the ISSUE cycle of a cpu write 0x05<=0xAAAA, with prior content 0x5555. Expect mem_we deasserted immediately, a later read of 0x05 returns 0x5555, and all outputs at reset values.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared constants and encodings for the LC-3 memory arbiter.
package lc3_mem_pkg;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_HOST = 1'b0,
    PORT_CPU  = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin on last_grant, or host-first when FIXED_PRIO.
// Vector bit 0 is the host port, bit 1 is the CPU port; grant is one-hot or zero.
module rr_arb2 import lc3_mem_pkg::*; #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] eligible,
  input  port_t      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FIXED_PRIO || (last_grant == PORT_CPU)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous-read LC-3 memory between the UART host path and the CPU,
// sequencing every access through IDLE -> ISSUE -> RESP.
module lc3_mem_arbiter #(
  parameter int AW         = lc3_mem_pkg::AW,
  parameter int DW         = lc3_mem_pkg::DW,
  parameter int DEPTH      = lc3_mem_pkg::DEPTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_err,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [6:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    conflict_cnt
);
  import lc3_mem_pkg::*;

  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until its one-cycle ack; a req still high during its own ack cycle is not
  // treated as a new request.

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  port_t         winner_q, last_grant_q, grant_port;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    eligible, grant;
  logic          in_range;

  assign eligible   = {cpu_req & ~cpu_ack, host_req & ~host_ack};
  assign grant_port = grant[1] ? PORT_CPU : PORT_HOST;
  assign in_range   = ({1'b0, addr_q} < DEPTH_LIM);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Memory strobes come only from state and latched fields, so reset kills them at once.
  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE:  if (|grant) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_RESP;
        mem_en  = in_range;
        mem_we  = in_range & we_q;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = addr_q[6:0];
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q     <= PORT_HOST;
      last_grant_q <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      host_rdata   <= '0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_rdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (&eligible) conflict_cnt <= conflict_cnt + 8'd1;
        if (|grant) begin
          winner_q     <= grant_port;
          last_grant_q <= grant_port;
          if (grant_port == PORT_CPU) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
          end else begin
            we_q    <= host_we;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
          end
        end
      end
      if (state_q == ST_RESP) begin
        if (winner_q == PORT_HOST) begin
          host_ack <= 1'b1;
          host_err <= ~in_range;
          if (!we_q) host_rdata <= in_range ? mem_rdata : '0;
        end else begin
          cpu_ack <= 1'b1;
          cpu_err <= ~in_range;
          if (!we_q) cpu_rdata <= in_range ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a round-robin instance and a fixed-priority
// instance, each backed by a 128x16 synchronous-read memory model.
module tb_lc3_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- round-robin instance ----------------
  logic        host_req, host_we, host_ack, host_err;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [7:0]  conflict_cnt;

  lc3_mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // ---------------- fixed-priority instance ----------------
  logic        f_host_req, f_host_we, f_host_ack, f_host_err;
  logic [7:0]  f_host_addr;
  logic [15:0] f_host_wdata, f_host_rdata;
  logic        f_cpu_req, f_cpu_we, f_cpu_ack, f_cpu_err;
  logic [7:0]  f_cpu_addr;
  logic [15:0] f_cpu_wdata, f_cpu_rdata;
  logic        f_mem_en, f_mem_we;
  logic [6:0]  f_mem_addr;
  logic [15:0] f_mem_wdata, f_mem_rdata;
  logic [7:0]  f_conflict_cnt;

  lc3_mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .host_req(f_host_req), .host_we(f_host_we), .host_addr(f_host_addr), .host_wdata(f_host_wdata),
    .host_ack(f_host_ack), .host_rdata(f_host_rdata), .host_err(f_host_err),
    .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
    .cpu_ack(f_cpu_ack), .cpu_rdata(f_cpu_rdata), .cpu_err(f_cpu_err),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .conflict_cnt(f_conflict_cnt)
  );

  // ---------------- memory models ----------------
  logic [15:0] mem_a [0:127];
  logic [15:0] mem_b [0:127];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_a[mem_addr] <= mem_wdata;
      mem_rdata <= mem_a[mem_addr];
    end
    if (f_mem_en) begin
      if (f_mem_we) mem_b[f_mem_addr] <= f_mem_wdata;
      f_mem_rdata <= mem_b[f_mem_addr];
    end
  end

  // ---------------- monitors ----------------
  int          en_cnt = 0, we_cnt = 0, h_ack_cnt = 0;
  logic [6:0]  we_addr;
  logic [15:0] we_data;

  always @(posedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_en && mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (host_ack) h_ack_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, passed = 0, fails = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_order(input string tag, input logic [0:0] obs);
    logic [0:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    check(tag, 32'(obs), 32'(e));
  endtask

  // ---------------- driver ----------------
  task automatic access(input bit is_cpu, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, input bit hold,
                        output int lat, output logic err);
    @(negedge clk);
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end
    lat = 0;
    err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if ((is_cpu ? cpu_ack : host_ack) === 1'b1) begin
        lat = i;
        err = is_cpu ? cpu_err : host_err;
        break;
      end
    end
    if (hold) @(posedge clk);
    @(negedge clk);
    if (is_cpu) cpu_req = 1'b0;
    else        host_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         lat, hn, cn, last_h, drop_c, en0, we0, h0;
    logic       err, ok;
    logic [7:0] cnt0, dcnt;

    rst = 1'b0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    f_host_req = 0; f_host_we = 0; f_host_addr = 0; f_host_wdata = 0;
    f_cpu_req = 0; f_cpu_we = 0; f_cpu_addr = 0; f_cpu_wdata = 0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_errs", 32'({host_err, cpu_err}), 0);
    check("rst_mem_en", 32'({mem_en, mem_we}), 0);
    check("rst_conflict", 32'(conflict_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // host write then read
    we0 = we_cnt;
    access(0, 1'b1, 8'h30, 16'hBEEF, 0, lat, err);
    check("wr30_latency", lat, 3);
    check("wr30_we_pulses", we_cnt - we0, 1);
    check("wr30_mem_addr", 32'(we_addr), 32'h30);
    check("wr30_mem_data", 32'(we_data), 32'hBEEF);
    we0 = we_cnt;
    access(0, 1'b0, 8'h30, 16'h0, 0, lat, err);
    check("rd30_latency", lat, 3);
    check("rd30_rdata", 32'(host_rdata), 32'hBEEF);
    check("rd30_err", 32'(err), 0);
    check("rd30_no_write", we_cnt - we0, 0);

    // preload
    access(0, 1'b1, 8'h10, 16'h1111, 0, lat, err);
    access(1, 1'b1, 8'h11, 16'h2222, 0, lat, err);
    access(1, 1'b1, 8'h05, 16'h5555, 0, lat, err);
    check("cpu_wr05_latency", lat, 3);

    // round-robin, both held: last grant was cpu so host leads
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    @(negedge clk);
    host_req = 1; host_we = 0; host_addr = 8'h10;
    cpu_req = 1;  cpu_we = 0;  cpu_addr = 8'h11;
    cnt0 = conflict_cnt; hn = 0; cn = 0; last_h = 0;
    for (int c = 1; c <= 60 && (hn < 5 || cn < 5); c++) begin
      @(posedge clk); #1;
      if (host_ack) begin
        check_order("rr_order", 1'b0);
        hn++; last_h = c;
        if (hn == 5) host_req = 0;
      end
      if (cpu_ack) begin
        check_order("rr_order", 1'b1);
        check("rr_cpu_gap", c - last_h, 3);
        cn++;
        if (cn == 5) cpu_req = 0;
      end
    end
    host_req = 0; cpu_req = 0;
    dcnt = conflict_cnt - cnt0;
    check("rr_host_acks", hn, 5);
    check("rr_cpu_acks", cn, 5);
    check("rr_queue_empty", exp_q.size(), 0);
    check("rr_conflicts", 32'(dcnt), 1);
    check("rr_host_rdata", 32'(host_rdata), 32'h1111);
    check("rr_cpu_rdata", 32'(cpu_rdata), 32'h2222);
    repeat (2) @(negedge clk);

    // round-robin after a host grant: cpu wins the conflict
    access(0, 1'b1, 8'h12, 16'h3333, 0, lat, err);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    @(negedge clk);
    host_req = 1; host_we = 0; host_addr = 8'h12;
    cpu_req = 1;  cpu_we = 0;  cpu_addr = 8'h10;
    cnt0 = conflict_cnt; hn = 0; cn = 0;
    for (int c = 1; c <= 20 && (hn < 1 || cn < 1); c++) begin
      @(posedge clk); #1;
      if (host_ack) begin check_order("rr2_order", 1'b0); hn++; host_req = 0; end
      if (cpu_ack) begin check_order("rr2_order", 1'b1); cn++; cpu_req = 0; end
    end
    host_req = 0; cpu_req = 0;
    dcnt = conflict_cnt - cnt0;
    check("rr2_acks", hn + cn, 2);
    check("rr2_conflicts", 32'(dcnt), 1);
    check("rr2_cpu_rdata", 32'(cpu_rdata), 32'h1111);
    check("rr2_host_rdata", 32'(host_rdata), 32'h3333);
    repeat (2) @(negedge clk);

    // fixed priority: prior grant is host, host still wins the conflict
    @(negedge clk);
    f_host_req = 1; f_host_we = 1; f_host_addr = 8'h20; f_host_wdata = 16'h0A0A;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (f_host_ack) begin ok = 1; break; end
    end
    check("fp_solo_ack", 32'(ok), 1);
    @(negedge clk);
    f_host_req = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    f_host_req = 1; f_host_we = 0; f_host_addr = 8'h20;
    f_cpu_req = 1;  f_cpu_we = 0;  f_cpu_addr = 8'h20;
    cnt0 = f_conflict_cnt; hn = 0; cn = 0; drop_c = 0;
    for (int c = 1; c <= 40 && cn < 3; c++) begin
      @(posedge clk); #1;
      if (f_host_ack) begin
        check_order("fp_order", 1'b0);
        hn++;
        if (hn == 3) begin f_host_req = 0; drop_c = c; end
      end
      if (f_cpu_ack) begin
        check_order("fp_order", 1'b1);
        cn++;
        if (cn == 3) begin
          f_cpu_req = 0;
          check("fp_cpu_after_drop", 32'((drop_c > 0) && (c - drop_c <= 3)), 1);
        end
      end
    end
    f_host_req = 0; f_cpu_req = 0;
    dcnt = f_conflict_cnt - cnt0;
    check("fp_acks", hn + cn, 6);
    check("fp_queue_empty", exp_q.size(), 0);
    check("fp_conflicts", 32'(dcnt), 1);
    check("fp_host_rdata", 32'(f_host_rdata), 32'h0A0A);
    check("fp_cpu_rdata", 32'(f_cpu_rdata), 32'h0A0A);
    repeat (2) @(negedge clk);

    // out of range
    en0 = en_cnt;
    access(1, 1'b1, 8'h80, 16'h1234, 0, lat, err);
    check("oor_wr_latency", lat, 3);
    check("oor_wr_err", 32'(err), 1);
    check("oor_wr_no_strobe", en_cnt - en0, 0);
    check("oor_err_pulse", 32'(cpu_err), 0);
    access(0, 1'b0, 8'h80, 16'h0, 0, lat, err);
    check("oor_rd_latency", lat, 3);
    check("oor_rd_err", 32'(err), 1);
    check("oor_rd_rdata", 32'(host_rdata), 0);
    check("oor_rd_no_strobe", en_cnt - en0, 0);

    // ack masking: req held through the ack cycle
    h0 = h_ack_cnt; en0 = en_cnt;
    access(0, 1'b0, 8'h30, 16'h0, 1, lat, err);
    repeat (4) @(negedge clk);
    check("mask_latency", lat, 3);
    check("mask_single_ack", h_ack_cnt - h0, 1);
    check("mask_single_access", en_cnt - en0, 1);
    check("mask_rdata", 32'(host_rdata), 32'hBEEF);

    // reset during the ISSUE cycle of a cpu write
    we0 = we_cnt;
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 16'hAAAA;
    @(posedge clk); #2;
    check("rstw_issue_strobe", 32'({mem_en, mem_we}), 32'h3);
    rst = 1'b0;
    #1;
    check("rstw_mem_we", 32'({mem_en, mem_we}), 0);
    check("rstw_acks", 32'({host_ack, cpu_ack}), 0);
    check("rstw_errs", 32'({host_err, cpu_err}), 0);
    check("rstw_host_rdata", 32'(host_rdata), 0);
    check("rstw_cpu_rdata", 32'(cpu_rdata), 0);
    check("rstw_conflict", 32'(conflict_cnt), 0);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_no_write", we_cnt - we0, 0);
    access(0, 1'b0, 8'h05, 16'h0, 0, lat, err);
    check("rstw_rd_latency", lat, 3);
    check("rstw_rd_rdata", 32'(host_rdata), 32'h5555);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
